prog_clk_div: RTL
=================

// Module: prog_clk_div
// PURPOSE
//  Multi-channel programmable clock/enable divider; supersedes the fixed even-only divider.
//  Each of NCH channels divides clk by a runtime divisor (any integer >= 1, odd included).
//  Each channel emits a registered divided clock and a one-cycle clock-enable tick.
//  Sits beside the CPU/peripheral clocking; ticks are the preferred enables for same-domain logic.
// PARAMETERS
//  NCH      4    number of independent channels (1..16)
//  DIV_W    16   divisor width in bits; divisor range 0..2^DIV_W-1
//  DEF_DIV  16   divisor loaded into every channel at reset (must be >= 1)
// PORTS
//  clk        in   1            system clock; all logic on posedge
//  rst_n      in   1            asynchronous, active-low reset
//  cfg_wr     in   1            config write strobe, one cycle per write
//  cfg_ch     in   clog2(NCH)   target channel of write
//  cfg_div    in   DIV_W        new divisor; 0 = stop channel
//  cfg_pend   out  NCH          bit i high while channel i holds an unapplied divisor
//  clk_out    out  NCH          divided clocks, registered
//  tick       out  NCH          1-cycle pulse coincident with each clk_out rising period start
//  sync       in   1            only with CLKDIV_SYNC_EN: phase-align all channels
// BEHAVIOUR
//  Reset: cur_div=DEF_DIV, cnt=DEF_DIV-1, pend_vld=0; clk_out=0, tick=0, cfg_pend=0.
//  Per channel, every clk: cnt counts 0..cur_div-1, then wraps to 0 (period boundary).
//  Outputs are registered from next-state (nd = next cur_div, nc = next cnt):
//   tick    <= (nd!=0) && (nc==0)
//   clk_out <= (nd!=0) && (nc < nd - nd/2)  => high ceil(D/2), low floor(D/2) cycles.
//  D=1: clk_out constantly 1, tick every cycle. D=2: 1-high/1-low. D=5: 3 high, 2 low.
//  First tick/rising clk_out: on the first clk edge after rst_n deasserts.
//  Divisor update: cfg_wr with cfg_ch<NCH stores cfg_div as pending (pend_vld=1).
//   Running channel: pending applied at next wrap (cnt=0 of new period uses new D);
//   the current period always completes with the old D, so no runt/glitch pulses.
//   Stopped channel (cur_div=0): pending applied next cycle; cnt restarts at 0.
//  Write of 0 to running channel: takes effect at boundary; then clk_out=0, tick=0, cnt=0.
//  Second write before application: overwrites pending value (last write wins).
//  Write in the same cycle as a wrap: the old pending (if any) applies at this wrap;
//   the new value becomes pending for the following boundary.
//  cfg_ch >= NCH: write ignored, no state changes.
//  cfg_pend is registered pend_vld: rises cycle after write, falls cycle after apply.
//  Asserting rst_n low mid-period: immediate return to reset values; pending dropped.
//  Counters are DIV_W bits; no arithmetic overflow since cnt <= cur_div-1.
// CONFIGURATION
//  CLKDIV_SYNC_EN defined: port sync present. sync=1 forces every running channel to
//   wrap on that edge (cnt<=0, pending applied), so all running channels tick together
//   the next cycle. Stopped channels unaffected. sync and cfg_wr same cycle: the write
//   becomes pending and is not applied by that sync.
//  CLKDIV_SYNC_EN undefined: no sync port; channels free-run, phases set only by
//   reset and divisor history. All other behaviour identical.
// STRUCTURE
//  Package clk_div_pkg: DIV_W default, channel-index width constant, chan-state struct
//   (cur_div, pend_div, pend_vld, cnt).
//  Sub-module clk_div_chan: one channel (counter, pending register, output regs),
//   generate-instantiated NCH times; top decodes cfg_ch into per-channel write strobes.
// TESTING
//  Reset, DEF_DIV=16, release -> ch0 tick at cycles 0,16,32; clk_out high 8 / low 8.
//  Write ch1 div=5 -> after boundary, clk_out 3 high / 2 low, tick period 5; D=1 -> clk_out=1, tick every cycle.
//  ch2 running D=4, write D=6 at cnt=1 -> period finishes 4 cycles, next period 6; cfg_pend high for the gap.
//  Write ch3 D=0 -> stops at boundary, outputs 0; write D=3 -> tick cycle after pend applied.
//  Write cfg_ch=NCH (e.g. 4) -> no channel changes, cfg_pend stays 0; two writes before boundary -> last applied.
//  CLKDIV_SYNC_EN: ch0 D=4, ch1 D=6 offset; pulse sync -> both tick next cycle; rst_n low mid-period -> outputs 0 at once.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
// Optional phase-align feature is enabled with `define CLKDIV_SYNC_EN.
package clk_div_pkg;

  localparam int DIV_W_DEF = 16;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prog_clk_div_if.sv
// Config and output bundle of prog_clk_div.
// The sync signal exists only when CLKDIV_SYNC_EN is defined.
interface prog_clk_div_if #(
  parameter int NCH   = 4,
  parameter int DIV_W = 16
);
  import clk_div_pkg::*;

  localparam int CH_W = ch_w(NCH);

  logic             cfg_wr;
  logic [CH_W-1:0]  cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic [NCH-1:0]   cfg_pend;
  logic [NCH-1:0]   clk_out;
  logic [NCH-1:0]   tick;
`ifdef CLKDIV_SYNC_EN
  logic             sync;
`endif

  modport master (
    output cfg_wr, cfg_ch, cfg_div,
`ifdef CLKDIV_SYNC_EN
    output sync,
`endif
    input  cfg_pend, clk_out, tick
  );

  modport slave (
    input  cfg_wr, cfg_ch, cfg_div,
`ifdef CLKDIV_SYNC_EN
    input  sync,
`endif
    output cfg_pend, clk_out, tick
  );

endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: counter, pending divisor, registered outputs.
// With CLKDIV_SYNC_EN, sync forces a wrap on a running channel.
module clk_div_chan #(
  parameter int DIV_W   = 16,
  parameter int DEF_DIV = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [DIV_W-1:0] wdiv,
`ifdef CLKDIV_SYNC_EN
  input  logic             sync,
`endif
  output logic             pend,
  output logic             clk_out,
  output logic             tick
);

  typedef struct packed {
    logic [DIV_W-1:0] cur_div;
    logic [DIV_W-1:0] pend_div;
    logic             pend_vld;
    logic [DIV_W-1:0] cnt;
  } st_t;

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  st_t              st;
  logic [DIV_W-1:0] nd;
  logic [DIV_W-1:0] nc;
  logic [DIV_W-1:0] hi_len;
  logic             apply;
  logic             force_wrap;

  always_comb begin
    force_wrap = 1'b0;
`ifdef CLKDIV_SYNC_EN
    force_wrap = sync;
`endif
    nd    = st.cur_div;
    nc    = st.cnt;
    apply = 1'b0;
    // a stopped channel picks up its pending divisor immediately
    if (st.cur_div == '0) begin
      nc    = '0;
      apply = st.pend_vld;
    end else if (force_wrap || st.cnt == st.cur_div - ONE) begin
      nc    = '0;
      apply = st.pend_vld;
    end else begin
      nc = st.cnt + ONE;
    end
    if (apply) nd = st.pend_div;
    hi_len = nd - (nd >> 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st.cur_div  <= DIV_W'(DEF_DIV);
      st.cnt      <= DIV_W'(DEF_DIV - 1);
      st.pend_div <= '0;
      st.pend_vld <= 1'b0;
      clk_out     <= 1'b0;
      tick        <= 1'b0;
    end else begin
      st.cur_div <= nd;
      st.cnt     <= nc;
      // a write on the apply edge becomes pending for the next boundary
      if (wr) begin
        st.pend_div <= wdiv;
        st.pend_vld <= 1'b1;
      end else if (apply) begin
        st.pend_vld <= 1'b0;
      end
      tick    <= (nd != '0) && (nc == '0);
      clk_out <= (nd != '0) && (nc < hi_len);
    end
  end

  assign pend = st.pend_vld;

endmodule

// File: rtl/prog_clk_div.sv
// Multi-channel programmable clock/enable divider.
// Define CLKDIV_SYNC_EN to add the sync phase-align input.
module prog_clk_div
  import clk_div_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int DIV_W   = DIV_W_DEF,
  parameter int DEF_DIV = 16
) (
  input logic          clk,
  input logic          rst_n,
  prog_clk_div_if.slave bus
);

  localparam int CH_W = ch_w(NCH);

  logic [NCH-1:0] pend;
  logic [NCH-1:0] clk_o;
  logic [NCH-1:0] tck;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic wr;
    assign wr = bus.cfg_wr && (bus.cfg_ch == CH_W'(g));

    clk_div_chan #(
      .DIV_W   (DIV_W),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr      (wr),
      .wdiv    (bus.cfg_div),
`ifdef CLKDIV_SYNC_EN
      .sync    (bus.sync),
`endif
      .pend    (pend[g]),
      .clk_out (clk_o[g]),
      .tick    (tck[g])
    );
  end

  assign bus.cfg_pend = pend;
  assign bus.clk_out  = clk_o;
  assign bus.tick     = tck;

endmodule
